// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Purpose : Collects register-file write-back requests from three sources
//           (0 = ALU, 1 = multdiv, 2 = load). Each source has a one-entry
//           holding buffer. A round-robin arbiter drains at most one buffer
//           per cycle into a registered register-file write port.
//           Writes to r0 (constant) and r1 (LFSR-owned) are retired
//           without raising the write strobe.
// Ports   :
//   clock            in   rising-edge clock
//   ctrl_reset       in   asynchronous active-high reset
//   req_valid[2:0]   in   per-source write request
//   req_reg          in   3 x ADDR_WIDTH destination indices
//   req_data         in   3 x DATA_WIDTH write data
//   req_ready[2:0]   out  source may transfer on this edge (combinational)
//   ctrl_writeEnable out  register-file write strobe (registered)
//   ctrl_writeReg    out  register-file write index (registered)
//   data_writeReg    out  register-file write data (registered)
//   pending[2:0]     out  holding buffer occupied flags
//   drop_count[7:0]  out  saturating count of r0/r1 retirements
//                         (only when WB_DROP_COUNT_EN is defined)
// Config  : `define WB_DROP_COUNT_EN to add the drop_count port and counter.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clock,
   input  logic                    ctrl_reset,
   input  logic [2:0]              req_valid,
   input  logic [3*ADDR_WIDTH-1:0] req_reg,
   input  logic [3*DATA_WIDTH-1:0] req_data,
   output logic [2:0]              req_ready,
   output logic                    ctrl_writeEnable,
   output logic [ADDR_WIDTH-1:0]   ctrl_writeReg,
   output logic [DATA_WIDTH-1:0]   data_writeReg,
   output logic [2:0]              pending
`ifdef WB_DROP_COUNT_EN
   ,output logic [7:0]             drop_count
`endif
);

   logic [2:0]            r_buf_valid;
   logic [ADDR_WIDTH-1:0] r_buf_reg  [0:2];
   logic [DATA_WIDTH-1:0] r_buf_data [0:2];
   logic [1:0]            r_ptr;      // last granted source

   logic [1:0] w_cand0, w_cand1, w_cand2;
   logic [1:0] w_grant_idx;
   logic       w_grant_any;
   logic [2:0] w_grant_vec;
   logic [2:0] w_xfer;

`ifdef WB_DROP_COUNT_EN
   logic [7:0] r_drop_count;
   assign drop_count = r_drop_count;
`endif

   // Search order starts at the source after the last granted one.
   always_comb begin
      w_cand0 = 2'd0;
      w_cand1 = 2'd1;
      w_cand2 = 2'd2;
      case (r_ptr)
         2'd0: begin
            w_cand0 = 2'd1;
            w_cand1 = 2'd2;
            w_cand2 = 2'd0;
         end
         2'd1: begin
            w_cand0 = 2'd2;
            w_cand1 = 2'd0;
            w_cand2 = 2'd1;
         end
         default: begin
            w_cand0 = 2'd0;
            w_cand1 = 2'd1;
            w_cand2 = 2'd2;
         end
      endcase
   end

   // First occupied buffer in search order wins the grant.
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = r_ptr;
      if (r_buf_valid[w_cand0]) begin
         w_grant_any = 1'b1;
         w_grant_idx = w_cand0;
      end else if (r_buf_valid[w_cand1]) begin
         w_grant_any = 1'b1;
         w_grant_idx = w_cand1;
      end else if (r_buf_valid[w_cand2]) begin
         w_grant_any = 1'b1;
         w_grant_idx = w_cand2;
      end else begin
         w_grant_any = 1'b0;
         w_grant_idx = r_ptr;
      end
   end

   // One-hot grant, ready and transfer qualifiers.
   always_comb begin
      w_grant_vec = 3'b000;
      if (w_grant_any) begin
         w_grant_vec[w_grant_idx] = 1'b1;
      end else begin
         w_grant_vec = 3'b000;
      end
      // A granted buffer frees up on this edge, so its source may refill it.
      req_ready = (~r_buf_valid | w_grant_vec) & {3{~ctrl_reset}};
      w_xfer    = req_valid & req_ready;
   end

   assign pending = r_buf_valid;

   // Buffers, round-robin pointer and registered write port.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         r_buf_valid      <= 3'b000;
         r_ptr            <= 2'd2;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
         for (int i = 0; i < 3; i++) begin
            r_buf_reg[i]  <= '0;
            r_buf_data[i] <= '0;
         end
`ifdef WB_DROP_COUNT_EN
         r_drop_count     <= 8'd0;
`endif
      end else begin
         ctrl_writeEnable <= 1'b0;
         if (w_grant_any) begin
            r_ptr <= w_grant_idx;
            // r0 and r1 are never written through this port.
            if (r_buf_reg[w_grant_idx] > ADDR_WIDTH'(1)) begin
               ctrl_writeEnable <= 1'b1;
               ctrl_writeReg    <= r_buf_reg[w_grant_idx];
               data_writeReg    <= r_buf_data[w_grant_idx];
            end else begin
`ifdef WB_DROP_COUNT_EN
               if (r_drop_count != 8'd255) begin
                  r_drop_count <= r_drop_count + 8'd1;
               end
`endif
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (w_xfer[i]) begin
               r_buf_valid[i] <= 1'b1;
               r_buf_reg[i]   <= req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
               r_buf_data[i]  <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (w_grant_vec[i]) begin
               r_buf_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed testbench for regfile_wb_arbiter. Inputs change 1 ns after each
// rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic            clock;
   logic            ctrl_reset;
   logic [2:0]      req_valid;
   logic [3*AW-1:0] req_reg;
   logic [3*DW-1:0] req_data;
   logic [2:0]      req_ready;
   logic            ctrl_writeEnable;
   logic [AW-1:0]   ctrl_writeReg;
   logic [DW-1:0]   data_writeReg;
   logic [2:0]      pending;
`ifdef WB_DROP_COUNT_EN
   logic [7:0]      drop_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .req_valid        (req_valid),
      .req_reg          (req_reg),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .pending          (pending)
`ifdef WB_DROP_COUNT_EN
      ,.drop_count      (drop_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [AW-1:0] r,
                          input logic [DW-1:0] d);
      req_valid[i]         = v;
      req_reg[i*AW +: AW]  = r;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      ctrl_reset = 1'b1;
      req_valid  = 3'b000;
      tick();
      ctrl_reset = 1'b0;
   endtask

   task automatic test_reset();
      ctrl_reset = 1'b1;
      req_valid  = 3'b111;
      req_reg    = '0;
      req_data   = '1;
      tick();
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: we=%b reg=%0d data=%h, required 0/0/0",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      n_tests++;
      if (pending !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_pending: got %b, required 000", pending);
      end
      n_tests++;
      if (req_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ready: got %b, required 000", req_ready);
      end
`ifdef WB_DROP_COUNT_EN
      n_tests++;
      if (drop_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_drop: got %0d, required 0", drop_count);
      end
`endif
      req_valid  = 3'b000;
      ctrl_reset = 1'b0;
      tick();
      n_tests++;
      if (req_ready !== 3'b111 || ctrl_writeEnable !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: ready=%b we=%b, required 111/0", req_ready, ctrl_writeEnable);
      end
   endtask

   task automatic test_single();
      set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      req_valid = 3'b000;
      n_tests++;
      if (pending !== 3'b001 || ctrl_writeEnable !== 1'b0) begin
         n_fail++;
         $display("FAIL single_buffered: pending=%b we=%b, required 001/0", pending, ctrl_writeEnable);
      end
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL single_write: we=%b reg=%0d data=%h, required 1/5/deadbeef",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL single_one_cycle: we=%b reg=%0d data=%h, required 0/5/deadbeef held",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
   endtask

   task automatic test_contend();
      logic [2:0] exp_ready [0:2];
      logic [2:0] exp_pend  [0:2];
      exp_ready[0] = 3'b001; exp_ready[1] = 3'b011; exp_ready[2] = 3'b111;
      exp_pend[0]  = 3'b111; exp_pend[1]  = 3'b110; exp_pend[2]  = 3'b100;
      do_reset();
      set_src(0, 1'b1, 5'd2, 32'h22);
      set_src(1, 1'b1, 5'd3, 32'h33);
      set_src(2, 1'b1, 5'd4, 32'h44);
      tick();
      req_valid = 3'b000;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (req_ready !== exp_ready[k] || pending !== exp_pend[k]) begin
            n_fail++;
            $display("FAIL contend_ready_%0d: ready=%b pending=%b, required %b/%b",
                     k, req_ready, pending, exp_ready[k], exp_pend[k]);
         end
         tick();
         n_tests++;
         if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== AW'(k + 2) ||
             data_writeReg !== DW'(32'h22 + 32'h11 * k)) begin
            n_fail++;
            $display("FAIL contend_write_%0d: we=%b reg=%0d data=%h, required 1/%0d/%h",
                     k, ctrl_writeEnable, ctrl_writeReg, data_writeReg, k + 2, 32'h22 + 32'h11 * k);
         end
      end
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b0 || pending !== 3'b000) begin
         n_fail++;
         $display("FAIL contend_drained: we=%b pending=%b, required 0/000", ctrl_writeEnable, pending);
      end
   endtask

   task automatic test_back_to_back();
      int strobes = 0;
      for (int k = 0; k < 8; k++) begin
         set_src(1, 1'b1, AW'(10 + k), DW'(32'h100 + k));
         n_tests++;
         if (req_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_ready_%0d: got %b, required 1", k, req_ready[1]);
         end
         tick();
         if (k > 0) begin
            n_tests++;
            if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== AW'(9 + k) ||
                data_writeReg !== DW'(32'h100 + k - 1)) begin
               n_fail++;
               $display("FAIL stream_write_%0d: we=%b reg=%0d, required 1/%0d", k,
                        ctrl_writeEnable, ctrl_writeReg, 9 + k);
            end
            if (ctrl_writeEnable === 1'b1) strobes++;
         end
      end
      req_valid = 3'b000;
      tick();
      if (ctrl_writeEnable === 1'b1) strobes++;
      n_tests++;
      if (ctrl_writeReg !== 5'd17 || data_writeReg !== 32'h107 || strobes != 8) begin
         n_fail++;
         $display("FAIL stream_last: reg=%0d data=%h strobes=%0d, required 17/107/8",
                  ctrl_writeReg, data_writeReg, strobes);
      end
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_end: we=%b, required 0", ctrl_writeEnable);
      end
   endtask

   task automatic test_drop();
      set_src(2, 1'b1, 5'd1, 32'h1234);
      tick();
      req_valid = 3'b000;
      n_tests++;
      if (pending !== 3'b100) begin
         n_fail++;
         $display("FAIL drop_buffered: pending=%b, required 100", pending);
      end
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b0 || pending !== 3'b000 ||
          ctrl_writeReg !== 5'd17 || data_writeReg !== 32'h107) begin
         n_fail++;
         $display("FAIL drop_retire: we=%b pending=%b reg=%0d data=%h, required 0/000/17/107",
                  ctrl_writeEnable, pending, ctrl_writeReg, data_writeReg);
      end
`ifdef WB_DROP_COUNT_EN
      n_tests++;
      if (drop_count !== 8'd1) begin
         n_fail++;
         $display("FAIL drop_count: got %0d, required 1", drop_count);
      end
`endif
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_quiet: we=%b, required 0", ctrl_writeEnable);
      end
   endtask

   task automatic test_same_reg();
      logic [DW-1:0] rf7;
      logic [DW-1:0] exp_d [0:1];
      exp_d[0] = 32'hA;
      exp_d[1] = 32'hB;
      rf7 = 32'h0;
      set_src(0, 1'b1, 5'd7, 32'hA);
      set_src(2, 1'b1, 5'd7, 32'hB);
      tick();
      req_valid = 3'b000;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_tests++;
         if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 || data_writeReg !== exp_d[k]) begin
            n_fail++;
            $display("FAIL same_reg_%0d: we=%b reg=%0d data=%h, required 1/7/%h",
                     k, ctrl_writeEnable, ctrl_writeReg, data_writeReg, exp_d[k]);
         end
         if (ctrl_writeEnable === 1'b1 && ctrl_writeReg === 5'd7) rf7 = data_writeReg;
      end
      n_tests++;
      if (rf7 !== 32'hB) begin
         n_fail++;
         $display("FAIL same_reg_final: reg7=%h, required b", rf7);
      end
   endtask

   task automatic test_reset_mid();
      int strobes = 0;
      set_src(1, 1'b1, 5'd8, 32'h81);
      set_src(2, 1'b1, 5'd9, 32'h92);
      tick();
      req_valid = 3'b000;
      n_tests++;
      if (pending !== 3'b110) begin
         n_fail++;
         $display("FAIL mid_pending: got %b, required 110", pending);
      end
      ctrl_reset = 1'b1;
      #1;
      n_tests++;
      if (pending !== 3'b000 || req_ready !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_reset_clear: pending=%b ready=%b, required 000/000", pending, req_ready);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (ctrl_writeEnable !== 1'b0) strobes++;
      end
      ctrl_reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (ctrl_writeEnable !== 1'b0) strobes++;
      end
      n_tests++;
      if (strobes != 0 || pending !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_no_strobe: strobes=%0d pending=%b, required 0/000", strobes, pending);
      end
      set_src(0, 1'b1, 5'd6, 32'h66);
      tick();
      req_valid = 3'b000;
      tick();
      n_tests++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd6 || data_writeReg !== 32'h66) begin
         n_fail++;
         $display("FAIL mid_first_write: we=%b reg=%0d data=%h, required 1/6/66",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contend();
      test_back_to_back();
      test_drop();
      test_same_reg();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of write data per source and to the register file.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width.
REQ-003 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 ctrl_reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  3  per-source write request; bit i = source i (0 ALU, 1 multdiv, 2 load).
REQ-006 req_reg  input  3*ADDR_WIDTH  destination index; source i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 req_data  input  3*DATA_WIDTH  write data; source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  3  source i may transfer on this edge.
REQ-009 ctrl_writeEnable  output  1  register-file write strobe, registered.
REQ-010 ctrl_writeReg  output  ADDR_WIDTH  register-file write index, registered.
REQ-011 data_writeReg  output  DATA_WIDTH  register-file write data, registered.
REQ-012 pending  output  3  bit i high while source i's holding buffer is occupied.

Function
REQ-013 Each source SHALL own a one-entry holding buffer (valid, reg, data); a transfer occurs on an edge where req_valid[i] and req_ready[i] are both high.
REQ-014 req_ready[i] SHALL be combinational: high when buffer i is empty or is granted in the current cycle, so one source can sustain one transfer per cycle.
REQ-015 Each cycle the arbiter SHALL grant at most one occupied buffer, round-robin, searching from the source after the last granted one and wrapping 2 -> 0.
REQ-016 On a grant edge, the granted buffer SHALL clear unless its source transfers on the same edge, in which case it SHALL hold the new entry.
REQ-017 On a grant edge with index >= 2, ctrl_writeEnable, ctrl_writeReg and data_writeReg SHALL load 1, the index and the data for exactly one cycle.
REQ-018 On a grant edge with index 0 or 1, the entry SHALL be retired with ctrl_writeEnable low, because r0 is constant and r1 is LFSR-owned.
REQ-019 With no grant, ctrl_writeEnable SHALL be 0, and ctrl_writeReg and data_writeReg SHALL hold their previous values.
REQ-020 Latency: data transferred on edge E SHALL appear on the write outputs after edge E+1 at the earliest; worst case is after edge E+3 with all three sources contending.
REQ-021 Two sources targeting the same register in one cycle SHALL be written in grant order, so the later-granted value persists.
REQ-022 pending[i] SHALL equal buffer i's valid bit.

Reset
REQ-023 While ctrl_reset is high, all buffers SHALL be empty, pending = 0, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, and the round-robin pointer SHALL be 2 (source 0 searched first).
REQ-024 Reset asserted mid-operation SHALL discard buffered entries without issuing any write.
REQ-025 req_ready SHALL be 0 while ctrl_reset is high.

Configuration
REQ-026 Macro WB_DROP_COUNT_EN, when defined, SHALL add output drop_count [7:0], reset to 0.
REQ-027 With WB_DROP_COUNT_EN defined, drop_count SHALL increment on each REQ-018 retirement and saturate at 255.
REQ-028 Without WB_DROP_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset release, then source 0 writes reg 5, data 0xDEADBEEF -> one cycle later ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF for exactly one cycle.
REQ-030 All three sources valid on one edge (regs 2, 3, 4) -> writes issue on three consecutive cycles in order 2, 3, 4; req_ready[1] and req_ready[2] stay low until their grants.
REQ-031 Source 1 streams 8 back-to-back writes (regs 10..17) -> req_ready[1] stays high throughout, with 8 consecutive strobes in order.
REQ-032 Source 2 writes reg 1 with 0x1234 -> buffer retires, ctrl_writeEnable stays 0, drop_count = 1 when WB_DROP_COUNT_EN is defined.
REQ-033 Sources 0 and 2 both target reg 7 (0xA, 0xB) on the same edge after pointer = 2 -> 0xA then 0xB are written, so reg 7 ends at 0xB.
REQ-034 ctrl_reset pulsed while sources 1 and 2 are pending -> pending = 0 and no strobe occurs; the first write after release comes from source 0.
